// File: rtl/matrix_scan.sv
// matrix_scan
//   Loads a matrix of up to 2**R_WIDTH x 2**C_WIDTH elements in row-major
//   order, then streams it back out in one of four scan orders: row-major,
//   column-major, clockwise spiral or counter-clockwise spiral. Loading and
//   draining never overlap: the input side is ready only while idle or
//   loading, and the output side is valid only while draining.
//
// Ports
//   clk            rising-edge clock
//   rstn           asynchronous active-low reset
//   row_m1/col_m1  matrix dimensions minus one, sampled on the first beat
//   mode           0 row-major, 1 column-major, 2 spiral CW, 3 spiral CCW
//   data_in*       load stream (valid/ready handshake)
//   data_out*      scan stream (valid/ready handshake), last marks final beat
//   busy           high while loading or draining
module matrix_scan #(
  parameter int DATA_WIDTH = 8,
  parameter int R_WIDTH    = 3,
  parameter int C_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [R_WIDTH-1:0]    row_m1,
  input  logic [C_WIDTH-1:0]    col_m1,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_rdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_rdy,
  output logic                  data_out_last,
  output logic                  busy
);

  localparam int ADDR_W = R_WIDTH + C_WIDTH;
  localparam int CNT_W  = R_WIDTH + C_WIDTH + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [R_WIDTH-1:0] R_ONE = R_WIDTH'(1);
  localparam logic [C_WIDTH-1:0] C_ONE = C_WIDTH'(1);
  localparam logic [CNT_W-1:0]   N_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  typedef enum logic [1:0] {L2R, U2D, R2L, D2U} dir_t;

  state_t               state_reg, state_next;
  dir_t                 dir_reg, dir_next;
  logic [1:0]           mode_reg, mode_next;
  logic [R_WIDTH-1:0]   row_lim_reg, row_lim_next;
  logic [C_WIDTH-1:0]   col_lim_reg, col_lim_next;
  logic [R_WIDTH-1:0]   wr_r_reg, wr_r_next;
  logic [C_WIDTH-1:0]   wr_c_reg, wr_c_next;
  logic [R_WIDTH-1:0]   rd_r_reg, rd_r_next;
  logic [C_WIDTH-1:0]   rd_c_reg, rd_c_next;
  logic [R_WIDTH-1:0]   top_reg, top_next, bottom_reg, bottom_next;
  logic [C_WIDTH-1:0]   left_reg, left_next, right_reg, right_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 in_rdy_reg, in_rdy_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                 in_fire;
  logic                 out_fire;
  logic                 cw;
  logic [R_WIDTH-1:0]   row_lim;
  logic [C_WIDTH-1:0]   col_lim;
  logic [CNT_W-1:0]     total;

  assign in_fire  = data_in_valid && in_rdy_reg;
  assign out_fire = (state_reg == DRAIN) && data_out_rdy;
  assign cw       = !mode_reg[0];

  // On the first beat the dimensions come straight from the ports; they are
  // captured into the limit registers on that same edge.
  assign row_lim = (state_reg == IDLE) ? row_m1 : row_lim_reg;
  assign col_lim = (state_reg == IDLE) ? col_m1 : col_lim_reg;
  assign total   = (CNT_W'(row_m1) + N_ONE) * (CNT_W'(col_m1) + N_ONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      dir_reg     <= L2R;
      mode_reg    <= '0;
      row_lim_reg <= '0;
      col_lim_reg <= '0;
      wr_r_reg    <= '0;
      wr_c_reg    <= '0;
      rd_r_reg    <= '0;
      rd_c_reg    <= '0;
      top_reg     <= '0;
      bottom_reg  <= '0;
      left_reg    <= '0;
      right_reg   <= '0;
      count_reg   <= '0;
      in_rdy_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dir_reg     <= dir_next;
      mode_reg    <= mode_next;
      row_lim_reg <= row_lim_next;
      col_lim_reg <= col_lim_next;
      wr_r_reg    <= wr_r_next;
      wr_c_reg    <= wr_c_next;
      rd_r_reg    <= rd_r_next;
      rd_c_reg    <= rd_c_next;
      top_reg     <= top_next;
      bottom_reg  <= bottom_next;
      left_reg    <= left_next;
      right_reg   <= right_next;
      count_reg   <= count_next;
      in_rdy_reg  <= in_rdy_next;
    end
  end

  // Storage is never reset; a write can only happen while the input is ready,
  // so the drain phase cannot disturb it.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[{wr_r_reg, wr_c_reg}] <= data_in;
    end
  end

  always_comb begin
    state_next   = state_reg;
    dir_next     = dir_reg;
    mode_next    = mode_reg;
    row_lim_next = row_lim_reg;
    col_lim_next = col_lim_reg;
    wr_r_next    = wr_r_reg;
    wr_c_next    = wr_c_reg;
    rd_r_next    = rd_r_reg;
    rd_c_next    = rd_c_reg;
    top_next     = top_reg;
    bottom_next  = bottom_reg;
    left_next    = left_reg;
    right_next   = right_reg;
    count_next   = count_reg;

    case (state_reg)
      IDLE, LOAD: begin
        if (in_fire) begin
          if (state_reg == IDLE) begin
            mode_next    = mode;
            row_lim_next = row_m1;
            col_lim_next = col_m1;
            count_next   = total;
            top_next     = '0;
            left_next    = '0;
            bottom_next  = row_m1;
            right_next   = col_m1;
            dir_next     = (mode == 2'd3) ? U2D : L2R;
            rd_r_next    = '0;
            rd_c_next    = '0;
            state_next   = LOAD;
          end
          if (wr_r_reg == row_lim && wr_c_reg == col_lim) begin
            state_next = DRAIN;
          end else if (wr_c_reg == col_lim) begin
            wr_c_next = '0;
            wr_r_next = wr_r_reg + R_ONE;
          end else begin
            wr_c_next = wr_c_reg + C_ONE;
          end
        end
      end

      DRAIN: begin
        if (out_fire) begin
          count_next = count_reg - N_ONE;
          if (count_reg == N_ONE) begin
            // Final element: return to a clean idle state.
            state_next  = IDLE;
            dir_next    = L2R;
            wr_r_next   = '0;
            wr_c_next   = '0;
            rd_r_next   = '0;
            rd_c_next   = '0;
            top_next    = '0;
            bottom_next = '0;
            left_next   = '0;
            right_next  = '0;
          end else begin
            case (mode_reg)
              2'd0: begin
                if (rd_c_reg == col_lim_reg) begin
                  rd_c_next = '0;
                  rd_r_next = rd_r_reg + R_ONE;
                end else begin
                  rd_c_next = rd_c_reg + C_ONE;
                end
              end
              2'd1: begin
                if (rd_r_reg == row_lim_reg) begin
                  rd_r_next = '0;
                  rd_c_next = rd_c_reg + C_ONE;
                end else begin
                  rd_r_next = rd_r_reg + R_ONE;
                end
              end
              default: begin
                // Spiral: walk in the current direction until the matching
                // bound is reached, then turn, shrinking the bound of the leg
                // just completed and stepping onto the first cell of the next.
                case (dir_reg)
                  L2R: begin
                    if (rd_c_reg != right_reg) begin
                      rd_c_next = rd_c_reg + C_ONE;
                    end else if (cw) begin
                      top_next  = top_reg + R_ONE;
                      dir_next  = U2D;
                      rd_r_next = rd_r_reg + R_ONE;
                    end else begin
                      bottom_next = bottom_reg - R_ONE;
                      dir_next    = D2U;
                      rd_r_next   = rd_r_reg - R_ONE;
                    end
                  end
                  U2D: begin
                    if (rd_r_reg != bottom_reg) begin
                      rd_r_next = rd_r_reg + R_ONE;
                    end else if (cw) begin
                      right_next = right_reg - C_ONE;
                      dir_next   = R2L;
                      rd_c_next  = rd_c_reg - C_ONE;
                    end else begin
                      left_next = left_reg + C_ONE;
                      dir_next  = L2R;
                      rd_c_next = rd_c_reg + C_ONE;
                    end
                  end
                  R2L: begin
                    if (rd_c_reg != left_reg) begin
                      rd_c_next = rd_c_reg - C_ONE;
                    end else if (cw) begin
                      bottom_next = bottom_reg - R_ONE;
                      dir_next    = D2U;
                      rd_r_next   = rd_r_reg - R_ONE;
                    end else begin
                      top_next  = top_reg + R_ONE;
                      dir_next  = U2D;
                      rd_r_next = rd_r_reg + R_ONE;
                    end
                  end
                  default: begin // D2U
                    if (rd_r_reg != top_reg) begin
                      rd_r_next = rd_r_reg - R_ONE;
                    end else if (cw) begin
                      left_next = left_reg + C_ONE;
                      dir_next  = L2R;
                      rd_c_next = rd_c_reg + C_ONE;
                    end else begin
                      right_next = right_reg - C_ONE;
                      dir_next   = R2L;
                      rd_c_next  = rd_c_reg - C_ONE;
                    end
                  end
                endcase
              end
            endcase
          end
        end
      end

      default: state_next = IDLE;
    endcase

    in_rdy_next = (state_next != DRAIN);
  end

  // The read address is registered and storage is frozen while draining, so
  // data_out holds steady through any output stall.
  assign data_out       = mem[{rd_r_reg, rd_c_reg}];
  assign data_out_valid = (state_reg == DRAIN);
  assign data_out_last  = data_out_valid && (count_reg == N_ONE);
  assign data_in_rdy    = in_rdy_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_matrix_scan.sv
module tb_matrix_scan;

  localparam int DW = 8;
  localparam int RW = 3;
  localparam int CW = 3;

  logic          clk;
  logic          rstn;
  logic [RW-1:0] row_m1;
  logic [CW-1:0] col_m1;
  logic [1:0]    mode;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          data_in_rdy;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_rdy;
  logic          data_out_last;
  logic          busy;

  matrix_scan #(.DATA_WIDTH(DW), .R_WIDTH(RW), .C_WIDTH(CW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .row_m1         (row_m1),
    .col_m1         (col_m1),
    .mode           (mode),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_rdy    (data_in_rdy),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_rdy   (data_out_rdy),
    .data_out_last  (data_out_last),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int out_log[$];
  int mat[64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference scan order, built from the loaded matrix independently of the
  // design's address walk.
  task automatic build_expected(input int rows, input int cols, input int md);
    int t, b, l, rt;
    exp_q.delete();
    if (md == 0) begin
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++) exp_q.push_back(mat[r*cols+c]);
    end else if (md == 1) begin
      for (int c = 0; c < cols; c++)
        for (int r = 0; r < rows; r++) exp_q.push_back(mat[r*cols+c]);
    end else begin
      t = 0; b = rows - 1; l = 0; rt = cols - 1;
      while (t <= b && l <= rt) begin
        if (md == 2) begin
          for (int c = l; c <= rt; c++) exp_q.push_back(mat[t*cols+c]);
          t++;
          for (int r = t; r <= b; r++) exp_q.push_back(mat[r*cols+rt]);
          rt--;
          if (t <= b) begin
            for (int c = rt; c >= l; c--) exp_q.push_back(mat[b*cols+c]);
            b--;
          end
          if (l <= rt) begin
            for (int r = b; r >= t; r--) exp_q.push_back(mat[r*cols+l]);
            l++;
          end
        end else begin
          for (int r = t; r <= b; r++) exp_q.push_back(mat[r*cols+l]);
          l++;
          for (int c = l; c <= rt; c++) exp_q.push_back(mat[b*cols+c]);
          b--;
          if (l <= rt) begin
            for (int r = b; r >= t; r--) exp_q.push_back(mat[r*cols+rt]);
            rt--;
          end
          if (t <= b) begin
            for (int c = rt; c >= l; c--) exp_q.push_back(mat[t*cols+c]);
            t++;
          end
        end
      end
    end
  endtask

  task automatic check_seq(input string tag, input int s[$]);
    check({tag, "_len"}, out_log.size(), s.size());
    for (int i = 0; i < s.size() && i < out_log.size(); i++)
      check(tag, out_log[i], s[i]);
  endtask

  task automatic run_matrix(input int rows, input int cols, input int md,
                            input int gap_pct, input int stall_pct,
                            input int abort_after, input bit rand_data);
    int idx, guard, cnt, e;
    bit stalled;
    logic [DW-1:0] held_d;
    logic held_l;
    for (int i = 0; i < rows*cols; i++)
      mat[i] = rand_data ? int'($urandom_range(0, 255)) : i + 1;
    build_expected(rows, cols, md);
    out_log.delete();

    @(negedge clk);
    row_m1 = RW'(rows - 1);
    col_m1 = CW'(cols - 1);
    mode   = 2'(md);
    idx = 0; guard = 0;
    while (idx < rows*cols && guard < 2000) begin
      data_in_valid = ($urandom_range(0, 99) >= gap_pct);
      data_in       = DW'(mat[idx]);
      e = int'(data_in_valid && data_in_rdy);
      @(negedge clk);
      if (e != 0) begin
        idx++;
        // Dimensions must have been captured on the first beat.
        if (idx == 1) begin
          row_m1 = RW'($urandom);
          col_m1 = CW'($urandom);
          mode   = 2'($urandom);
        end
      end
      guard++;
    end
    if (guard >= 2000) check("load_timeout", 0, 1);

    // One cycle after the last write the first element must be presented.
    check("first_valid", data_out_valid, 1);
    check("drain_in_rdy", data_in_rdy, 0);
    check("drain_busy", busy, 1);

    // Inputs offered during the drain must be ignored.
    data_in_valid = 1'b1;
    data_in       = 8'hEE;
    cnt = 0; guard = 0; stalled = 0; held_d = '0; held_l = 1'b0;
    while (exp_q.size() > 0 && guard < 5000) begin
      if (stalled) begin
        check("stall_data", data_out, held_d);
        check("stall_last", data_out_last, held_l);
      end
      data_out_rdy = ($urandom_range(0, 99) >= stall_pct);
      if (data_out_valid && data_out_rdy) begin
        e = exp_q.pop_front();
        check("data", data_out, e);
        check("last", data_out_last, (exp_q.size() == 0));
        out_log.push_back(int'(data_out));
        cnt++;
        stalled = 0;
        if (exp_q.size() == 0) data_in_valid = 1'b0;
      end else if (data_out_valid) begin
        stalled = 1;
        held_d  = data_out;
        held_l  = data_out_last;
      end
      @(negedge clk);
      guard++;
      if (abort_after > 0 && cnt == abort_after) break;
    end
    data_out_rdy  = 1'b0;
    data_in_valid = 1'b0;
    if (guard >= 5000) check("drain_timeout", 0, 1);

    if (abort_after > 0) begin
      rstn = 1'b0;
      #1;
      check("abort_valid", data_out_valid, 0);
      check("abort_last", data_out_last, 0);
      check("abort_in_rdy", data_in_rdy, 0);
      check("abort_busy", busy, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("abort_rel_in_rdy", data_in_rdy, 1);
      data_out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
        check("abort_no_output", data_out_valid, 0);
        @(negedge clk);
      end
      data_out_rdy = 1'b0;
      $display("run %0dx%0d mode=%0d aborted after %0d beats", rows, cols, md, cnt);
    end else begin
      check("end_valid", data_out_valid, 0);
      check("end_in_rdy", data_in_rdy, 1);
      check("end_busy", busy, 0);
      $display("run %0dx%0d mode=%0d beats=%0d", rows, cols, md, cnt);
    end
  endtask

  initial begin
    int s[$];
    rstn = 1'b0;
    row_m1 = '0; col_m1 = '0; mode = '0;
    data_in = '0; data_in_valid = 1'b0; data_out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_rdy", data_in_rdy, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_last", data_out_last, 0);
    check("rst_busy", busy, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_in_rdy", data_in_rdy, 1);
    check("rel_valid", data_out_valid, 0);

    run_matrix(3, 3, 2, 0, 0, 0, 0);
    s = {1, 2, 3, 6, 9, 8, 7, 4, 5};
    check_seq("cw3x3", s);

    run_matrix(3, 3, 3, 0, 0, 0, 0);
    s = {1, 4, 7, 8, 9, 6, 3, 2, 5};
    check_seq("ccw3x3", s);

    run_matrix(2, 3, 1, 0, 0, 0, 0);
    s = {1, 4, 2, 5, 3, 6};
    check_seq("col2x3", s);

    run_matrix(1, 4, 2, 0, 0, 0, 0);
    s = {1, 2, 3, 4};
    check_seq("cw1x4", s);

    run_matrix(4, 1, 2, 0, 0, 0, 0);
    check_seq("cw4x1", s);

    run_matrix(1, 1, 0, 0, 0, 0, 0);
    s = {1};
    check_seq("one1x1", s);

    run_matrix(3, 4, 0, 20, 20, 0, 1);
    run_matrix(4, 3, 3, 20, 20, 0, 1);
    run_matrix(2, 5, 2, 20, 30, 0, 1);
    run_matrix(8, 8, 2, 30, 40, 0, 1);
    check("cw8x8_beats", out_log.size(), 64);

    run_matrix(4, 4, 0, 0, 0, 5, 0);
    run_matrix(2, 2, 2, 0, 0, 0, 0);
    s = {1, 2, 4, 3};
    check_seq("cw2x2_after_rst", s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_scan.md
MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter R_WIDTH, default 3, row-index width; MAX_R = 2**R_WIDTH.
REQ-003 SHALL have parameter C_WIDTH, default 3, column-index width; MAX_C = 2**C_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port row_m1  input  R_WIDTH  rows minus one (1..MAX_R rows, no forbidden value).
REQ-007 SHALL have port col_m1  input  C_WIDTH  columns minus one (1..MAX_C columns).
REQ-008 SHALL have port mode  input  2  scan order: 0 row-major, 1 column-major, 2 spiral clockwise, 3 spiral counter-clockwise.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  element, row-major load order.
REQ-010 SHALL have port data_in_valid  input  1  data_in valid.
REQ-011 SHALL have port data_in_rdy  output  1  block accepts data_in.
REQ-012 SHALL have port data_out  output  DATA_WIDTH  scanned element.
REQ-013 SHALL have port data_out_valid  output  1  data_out valid.
REQ-014 SHALL have port data_out_rdy  input  1  sink accepts data_out.
REQ-015 SHALL have port data_out_last  output  1  high with final element of the matrix.
REQ-016 SHALL have port busy  output  1  high in LOAD or DRAIN.

Function
REQ-017 SHALL implement states IDLE, LOAD, DRAIN; spiral direction sub-state L2R, U2D, R2L, D2U within DRAIN.
REQ-018 SHALL assert data_in_rdy exactly in IDLE and LOAD, data_out_valid exactly in DRAIN; load and drain never overlap.
REQ-019 SHALL transfer an input beat only when data_in_valid && data_in_rdy, an output beat only when data_out_valid && data_out_rdy.
REQ-020 SHALL latch row_m1, col_m1, mode on the first accepted beat in IDLE; later changes are ignored until next IDLE.
REQ-021 SHALL write beats to row-major addresses (r,c), c incrementing and wrapping to 0 with r+1 at c==col_m1.
REQ-022 SHALL move IDLE->LOAD on first beat, or IDLE->DRAIN if matrix is 1x1; LOAD->DRAIN on beat (row_m1,col_m1).
REQ-023 SHALL raise data_out_valid the cycle after the last write, presenting the first scan element (latency 1 cycle).
REQ-024 SHALL drive data_out from storage at the registered read address; data_out, data_out_last held stable while valid && !rdy.
REQ-025 SHALL use a remaining-element counter of width R_WIDTH+C_WIDTH+1 loaded with (row_m1+1)*(col_m1+1); data_out_last = (counter==1).
REQ-026 SHALL, on the last output handshake, go DRAIN->IDLE, reset read/write addresses and bounds to 0, data_in_rdy high next cycle.
REQ-027 Mode 0 SHALL emit r=0..row_m1 outer, c=0..col_m1 inner; mode 1 SHALL emit c outer, r inner.
REQ-028 Mode 2 SHALL start (0,0) L2R along top, then U2D right, R2L bottom, D2U left, shrinking top/right/bottom/left bounds after each leg.
REQ-029 Mode 3 SHALL start (0,0) U2D along left, then L2R bottom, D2U right, R2L top, shrinking bounds likewise.
REQ-030 Spiral SHALL emit each element exactly once, incl. single-row, single-column and non-square matrices; termination by counter only.
REQ-031 SHALL accept no input and alter no storage during DRAIN; data_in_valid there is ignored.
REQ-032 All address/bound arithmetic SHALL stay within declared widths; no wrap occurs for legal dimensions.

Reset
REQ-033 SHALL, on rstn low, asynchronously set state IDLE, data_in_rdy 0, data_out_valid 0, data_out_last 0, busy 0, counters/addresses/bounds 0.
REQ-034 SHALL assert data_in_rdy the first clock edge after rstn deasserts; storage contents need not reset.
REQ-035 Reset mid-LOAD or mid-DRAIN SHALL abandon the matrix; no output after release until a new full load.

Verification
REQ-036 3x3, mode 2, data 1..9 -> outputs 1,2,3,6,9,8,7,4,5, last with 5.
REQ-037 3x3, mode 3, data 1..9 -> 1,4,7,8,9,6,3,2,5; 2x3 mode 1, data 1..6 -> 1,4,2,5,3,6.
REQ-038 1x4 and 4x1, mode 2, data 1..4 -> 1,2,3,4 each, no repeats; 1x1 -> single beat, last=1, valid one cycle after load.
REQ-039 8x8 mode 2 with random data_out_rdy and data_in_valid gaps -> 64 beats matching model, outputs stable under stall.
REQ-040 rstn low after 5 outputs of 4x4 drain -> valid 0 immediately, rdy 1 after release, next 2x2 load/drain correct.
